// File: rtl/llc_set_reader_pkg.sv
// Shared LLC cache types and constants used by the set reader and its lookup logic.
package llc_set_reader_pkg;

  localparam int LLC_WAYS     = 16;
  localparam int LLC_WAY_BITS = $clog2(LLC_WAYS);
  localparam int LLC_SET_BITS = 8;
  localparam int LLC_TAG_BITS = 12;
  localparam int LINE_BITS    = 64;
  localparam int HPROT_BITS   = 1;
  localparam int OWNER_BITS   = 4;
  localparam int SHARERS_BITS = 16;

  typedef logic [2:0]              llc_state_t;
  typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
  typedef logic [LINE_BITS-1:0]    line_t;
  typedef logic [HPROT_BITS-1:0]   hprot_t;
  typedef logic [OWNER_BITS-1:0]   owner_t;
  typedef logic [SHARERS_BITS-1:0] sharers_t;
  typedef logic [LLC_WAY_BITS-1:0] llc_way_t;

  localparam llc_state_t INVALID   = 3'd0;
  localparam llc_state_t VALID     = 3'd1;
  localparam llc_state_t SHARED    = 3'd2;
  localparam llc_state_t EXCLUSIVE = 3'd3;
  localparam llc_state_t MODIFIED  = 3'd4;

endpackage

// File: rtl/llc_set_reader_if.sv
// Set-read request handshake between the LLC controller and the set reader.
interface llc_set_reader_if
  import llc_set_reader_pkg::*;
();

  logic                    rd_set_valid;
  logic [LLC_SET_BITS-1:0] rd_set;
  logic                    rd_set_ready;

  modport master (output rd_set_valid, rd_set, input rd_set_ready);
  modport slave  (input rd_set_valid, rd_set, output rd_set_ready);

endinterface

// File: rtl/llc_way_lookup.sv
// Combinational tag hit / first-empty / evict-pointer way selection over one captured set.
module llc_way_lookup
  import llc_set_reader_pkg::*;
#(
  parameter int WAYS = LLC_WAYS
) (
  input  logic       valid,
  input  llc_state_t states [WAYS],
  input  llc_tag_t   tags [WAYS],
  input  llc_tag_t   lookup_tag,
  input  llc_way_t   evict_way,
  output logic       hit,
  output llc_way_t   hit_way,
  output logic       empty_found,
  output llc_way_t   empty_way,
  output llc_way_t   way
);

  // Scanning downward lets the lowest matching index overwrite any higher one.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    empty_found = 1'b0;
    empty_way   = '0;
    if (valid) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (states[w] != INVALID && tags[w] == lookup_tag) begin
          hit     = 1'b1;
          hit_way = llc_way_t'(w);
        end
        if (states[w] == INVALID) begin
          empty_found = 1'b1;
          empty_way   = llc_way_t'(w);
        end
      end
    end
    if (hit)
      way = hit_way;
    else if (empty_found)
      way = empty_way;
    else if (valid)
      way = evict_way;
    else
      way = '0;
  end

endmodule

// File: rtl/llc_set_reader.sv
// Reads every way of one LLC set, waits out the RAM latency and captures the set into buffers.
// state   | meaning
// IDLE    | ready; a request fires rd_en this cycle
// WAIT    | RAM read in flight, counter running down
// CAPTURE | RAM data valid, buffers load at the edge
module llc_set_reader
  import llc_set_reader_pkg::*;
#(
  parameter int WAYS        = LLC_WAYS,
  parameter int RAM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  llc_set_reader_if.slave         req,
  output logic                    rd_en,
  output logic [LLC_SET_BITS-1:0] rd_addr,
  input  llc_state_t              ram_state [WAYS],
  input  llc_tag_t                ram_tag [WAYS],
  input  line_t                   ram_line [WAYS],
  input  hprot_t                  ram_hprot [WAYS],
  input  owner_t                  ram_owner [WAYS],
  input  sharers_t                ram_sharers [WAYS],
  input  logic                    ram_dirty_bit [WAYS],
  input  llc_way_t                ram_evict_way,
  output llc_state_t              states_buf [WAYS],
  output llc_tag_t                tags_buf [WAYS],
  output line_t                   lines_buf [WAYS],
  output hprot_t                  hprots_buf [WAYS],
  output owner_t                  owners_buf [WAYS],
  output sharers_t                sharers_buf [WAYS],
  output logic                    dirty_bits_buf [WAYS],
  output llc_way_t                evict_way_buf,
  output logic [LLC_SET_BITS-1:0] buf_set,
  output logic                    buf_valid,
  output logic                    done,
  input  logic                    buf_clear,
  input  llc_tag_t                lookup_tag,
  output logic                    hit,
  output llc_way_t                hit_way,
  output logic                    empty_found,
  output llc_way_t                empty_way,
  output llc_way_t                way
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} fsm_t;

  fsm_t                    state, state_next;
  logic [2:0]              cnt, cnt_next;
  logic [LLC_SET_BITS-1:0] set_q;
  logic                    accept;
  logic                    ready;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = !rst;
        if (req.rd_set_valid && !rst) begin
          accept     = 1'b1;
          cnt_next   = 3'(RAM_LATENCY - 1);
          state_next = (RAM_LATENCY > 1) ? WAIT : CAPTURE;
        end
      end
      WAIT: begin
        cnt_next = cnt - 3'd1;
        if (cnt == 3'd1)
          state_next = CAPTURE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req.rd_set_ready = ready;
  assign rd_en            = accept;
  assign rd_addr          = accept ? req.rd_set : set_q;

  // Capture takes priority over buf_clear; clear never touches buffer contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      set_q         <= '0;
      done          <= 1'b0;
      buf_valid     <= 1'b0;
      buf_set       <= '0;
      evict_way_buf <= '0;
      for (int w = 0; w < WAYS; w++) begin
        states_buf[w]     <= '0;
        tags_buf[w]       <= '0;
        lines_buf[w]      <= '0;
        hprots_buf[w]     <= '0;
        owners_buf[w]     <= '0;
        sharers_buf[w]    <= '0;
        dirty_bits_buf[w] <= 1'b0;
      end
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= (state == CAPTURE);
      if (accept)
        set_q <= req.rd_set;
      if (state == CAPTURE) begin
        buf_valid     <= 1'b1;
        buf_set       <= set_q;
        evict_way_buf <= ram_evict_way;
        for (int w = 0; w < WAYS; w++) begin
          states_buf[w]     <= ram_state[w];
          tags_buf[w]       <= ram_tag[w];
          lines_buf[w]      <= ram_line[w];
          hprots_buf[w]     <= ram_hprot[w];
          owners_buf[w]     <= ram_owner[w];
          sharers_buf[w]    <= ram_sharers[w];
          dirty_bits_buf[w] <= ram_dirty_bit[w];
        end
      end else if (buf_clear) begin
        buf_valid <= 1'b0;
      end
    end
  end

  llc_way_lookup #(.WAYS(WAYS)) u_lookup (
    .valid       (buf_valid),
    .states      (states_buf),
    .tags        (tags_buf),
    .lookup_tag  (lookup_tag),
    .evict_way   (evict_way_buf),
    .hit         (hit),
    .hit_way     (hit_way),
    .empty_found (empty_found),
    .empty_way   (empty_way),
    .way         (way)
  );

endmodule

// File: tb/tb_llc_set_reader.sv
// Bench for llc_set_reader: latency-2 and latency-1 instances against a delayed-RAM model and lookup reference.
module tb_llc_set_reader;
  import llc_set_reader_pkg::*;

  localparam int W = LLC_WAYS;
  typedef logic [LLC_SET_BITS-1:0] set_t;

  logic     clk = 1'b0;
  logic     rst;
  logic     clr_a, clr_b;
  llc_tag_t lookup_tag;
  int       checks = 0;
  int       failures = 0;

  always #5 clk = ~clk;

  // Content the RAM returns for the set currently being read.
  llc_state_t c_state [W];
  llc_tag_t   c_tag [W];
  line_t      c_line [W];
  hprot_t     c_hprot [W];
  owner_t     c_owner [W];
  sharers_t   c_sharers [W];
  logic       c_dirty [W];
  llc_way_t   c_evict;
  set_t       cur_set;
  set_t       pv_set;
  logic       pv_valid;
  logic [9:0] en_seen, done_seen;
  set_t       s_tmp;

  llc_set_reader_if if_a ();
  llc_set_reader_if if_b ();

  logic       rd_en_a, rd_en_b, bv_a, bv_b, done_a, done_b;
  logic       hit_a, hit_b, ef_a, ef_b;
  set_t       rd_addr_a, rd_addr_b, bs_a, bs_b;
  llc_way_t   hw_a, hw_b, ew_a, ew_b, way_a, way_b, eb_a, eb_b, re_a, re_b;
  llc_state_t rs_a [W], rs_b [W], sb_a [W], sb_b [W];
  llc_tag_t   rt_a [W], rt_b [W], tb_a [W], tb_b [W];
  line_t      rl_a [W], rl_b [W], lb_a [W], lb_b [W];
  hprot_t     rh_a [W], rh_b [W], hb_a [W], hb_b [W];
  owner_t     ro_a [W], ro_b [W], ob_a [W], ob_b [W];
  sharers_t   rsh_a [W], rsh_b [W], shb_a [W], shb_b [W];
  logic       rdb_a [W], rdb_b [W], db_a [W], db_b [W];

  llc_set_reader #(.WAYS(W), .RAM_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req(if_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .ram_state(rs_a), .ram_tag(rt_a), .ram_line(rl_a), .ram_hprot(rh_a), .ram_owner(ro_a),
    .ram_sharers(rsh_a), .ram_dirty_bit(rdb_a), .ram_evict_way(re_a),
    .states_buf(sb_a), .tags_buf(tb_a), .lines_buf(lb_a), .hprots_buf(hb_a), .owners_buf(ob_a),
    .sharers_buf(shb_a), .dirty_bits_buf(db_a), .evict_way_buf(eb_a),
    .buf_set(bs_a), .buf_valid(bv_a), .done(done_a), .buf_clear(clr_a), .lookup_tag(lookup_tag),
    .hit(hit_a), .hit_way(hw_a), .empty_found(ef_a), .empty_way(ew_a), .way(way_a));

  llc_set_reader #(.WAYS(W), .RAM_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .req(if_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .ram_state(rs_b), .ram_tag(rt_b), .ram_line(rl_b), .ram_hprot(rh_b), .ram_owner(ro_b),
    .ram_sharers(rsh_b), .ram_dirty_bit(rdb_b), .ram_evict_way(re_b),
    .states_buf(sb_b), .tags_buf(tb_b), .lines_buf(lb_b), .hprots_buf(hb_b), .owners_buf(ob_b),
    .sharers_buf(shb_b), .dirty_bits_buf(db_b), .evict_way_buf(eb_b),
    .buf_set(bs_b), .buf_valid(bv_b), .done(done_b), .buf_clear(clr_b), .lookup_tag(lookup_tag),
    .hit(hit_b), .hit_way(hw_b), .empty_found(ef_b), .empty_way(ew_b), .way(way_b));

  // RAM model: content appears only in the cycle RAM_LATENCY after an rd_en for cur_set, junk otherwise.
  logic [1:0] hist_a = '0;
  logic       hist_b = 1'b0;
  set_t       addr_a0 = '0, addr_a1 = '0, addr_b0 = '0;
  logic       valid_a, valid_b;

  always @(posedge clk) begin
    hist_a  <= {hist_a[0], rd_en_a};
    addr_a0 <= rd_addr_a;
    addr_a1 <= addr_a0;
    hist_b  <= rd_en_b;
    addr_b0 <= rd_addr_b;
  end

  assign valid_a = hist_a[1] && (addr_a1 == cur_set);
  assign valid_b = hist_b && (addr_b0 == cur_set);

  always_comb begin
    for (int w = 0; w < W; w++) begin
      rs_a[w]  = valid_a ? c_state[w] : 3'd7;
      rt_a[w]  = valid_a ? c_tag[w] : ~c_tag[w];
      rl_a[w]  = valid_a ? c_line[w] : ~c_line[w];
      rh_a[w]  = valid_a ? c_hprot[w] : ~c_hprot[w];
      ro_a[w]  = valid_a ? c_owner[w] : ~c_owner[w];
      rsh_a[w] = valid_a ? c_sharers[w] : ~c_sharers[w];
      rdb_a[w] = valid_a ? c_dirty[w] : ~c_dirty[w];
      rs_b[w]  = valid_b ? c_state[w] : 3'd7;
      rt_b[w]  = valid_b ? c_tag[w] : ~c_tag[w];
      rl_b[w]  = valid_b ? c_line[w] : ~c_line[w];
      rh_b[w]  = valid_b ? c_hprot[w] : ~c_hprot[w];
      ro_b[w]  = valid_b ? c_owner[w] : ~c_owner[w];
      rsh_b[w] = valid_b ? c_sharers[w] : ~c_sharers[w];
      rdb_b[w] = valid_b ? c_dirty[w] : ~c_dirty[w];
    end
    re_a = valid_a ? c_evict : ~c_evict;
    re_b = valid_b ? c_evict : ~c_evict;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tags come from a small pool so random lookups produce real collisions.
  task automatic rand_content(input int pct_invalid);
    for (int w = 0; w < W; w++) begin
      c_state[w]   = ($urandom_range(99) < pct_invalid) ? INVALID : llc_state_t'($urandom_range(4, 1));
      c_tag[w]     = llc_tag_t'($urandom_range(15));
      c_line[w]    = {$urandom, $urandom};
      c_hprot[w]   = hprot_t'($urandom);
      c_owner[w]   = owner_t'($urandom);
      c_sharers[w] = sharers_t'($urandom);
      c_dirty[w]   = 1'($urandom);
    end
    c_evict = llc_way_t'($urandom);
  endtask

  // Reference: first non-INVALID way with matching tag, else first INVALID way, else the evict pointer.
  task automatic model_lookup(input llc_tag_t t, output logic e_hit, output llc_way_t e_hw,
                              output logic e_ef, output llc_way_t e_ew, output llc_way_t e_way);
    int hw = -1;
    int ew = -1;
    for (int w = 0; w < W; w++) begin
      if (hw < 0 && c_state[w] != INVALID && c_tag[w] == t) hw = w;
      if (ew < 0 && c_state[w] == INVALID) ew = w;
    end
    e_hit = (hw >= 0);
    e_hw  = (hw >= 0) ? llc_way_t'(hw) : '0;
    e_ef  = (ew >= 0);
    e_ew  = (ew >= 0) ? llc_way_t'(ew) : '0;
    e_way = (hw >= 0) ? llc_way_t'(hw) : (ew >= 0) ? llc_way_t'(ew) : c_evict;
  endtask

  task automatic check_bufs_a(input string tag);
    for (int w = 0; w < W; w++) begin
      chk($sformatf("%s_meta_w%0d", tag, w), {sb_a[w], tb_a[w], hb_a[w], ob_a[w], shb_a[w], db_a[w]},
          {c_state[w], c_tag[w], c_hprot[w], c_owner[w], c_sharers[w], c_dirty[w]});
      chk($sformatf("%s_line_w%0d", tag, w), lb_a[w], c_line[w]);
    end
    chk({tag, "_evict"}, eb_a, c_evict);
  endtask

  task automatic check_lookup_a(input string tag, input llc_tag_t t);
    logic e_hit, e_ef;
    llc_way_t e_hw, e_ew, e_way;
    @(negedge clk);
    lookup_tag = t;
    #1;
    model_lookup(t, e_hit, e_hw, e_ef, e_ew, e_way);
    chk({tag, "_hit"}, hit_a, e_hit);
    chk({tag, "_hit_way"}, hw_a, e_hw);
    chk({tag, "_empty_found"}, ef_a, e_ef);
    chk({tag, "_empty_way"}, ew_a, e_ew);
    chk({tag, "_way"}, way_a, e_way);
  endtask

  // One request on the latency-2 instance, cycle by cycle from acceptance T to T+4.
  task automatic do_read_a(input string tag, input set_t s, input logic clear_in_capture);
    cur_set = s;
    @(negedge clk);
    if_a.rd_set_valid = 1'b1;
    if_a.rd_set = s;
    #1;
    chk({tag, "_T_rd_en"}, rd_en_a, 1'b1);
    chk({tag, "_T_rd_addr"}, rd_addr_a, s);
    @(negedge clk);
    if_a.rd_set_valid = 1'b0;
    if_a.rd_set = ~s;
    #1;
    chk({tag, "_T1_rd_en"}, rd_en_a, 1'b0);
    chk({tag, "_T1_rd_addr"}, rd_addr_a, s);
    chk({tag, "_T1_done"}, done_a, 1'b0);
    chk({tag, "_T1_old_valid"}, bv_a, pv_valid);
    if (pv_valid) chk({tag, "_T1_old_set"}, bs_a, pv_set);
    @(negedge clk);
    clr_a = clear_in_capture;
    #1;
    chk({tag, "_T2_done"}, done_a, 1'b0);
    chk({tag, "_T2_ready"}, if_a.rd_set_ready, 1'b0);
    @(negedge clk);
    clr_a = 1'b0;
    #1;
    chk({tag, "_T3_done"}, done_a, 1'b1);
    chk({tag, "_T3_buf_valid"}, bv_a, 1'b1);
    chk({tag, "_T3_buf_set"}, bs_a, s);
    chk({tag, "_T3_ready"}, if_a.rd_set_ready, 1'b1);
    check_bufs_a(tag);
    @(negedge clk);
    #1;
    chk({tag, "_T4_done"}, done_a, 1'b0);
    pv_valid = 1'b1;
    pv_set = s;
  endtask

  initial begin
    logic e_hit, e_ef;
    llc_way_t e_hw, e_ew, e_way;

    rst = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    lookup_tag = '0;
    if_a.rd_set_valid = 1'b0;
    if_a.rd_set = '0;
    if_b.rd_set_valid = 1'b0;
    if_b.rd_set = '0;
    pv_valid = 1'b0;
    pv_set = '0;
    cur_set = '0;
    rand_content(0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    if_a.rd_set_valid = 1'b1;
    #1;
    chk("rst_ready_low", if_a.rd_set_ready, 1'b0);
    chk("rst_rd_en_low", rd_en_a, 1'b0);
    if_a.rd_set_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", if_a.rd_set_ready, 1'b1);
    chk("reset_buf_valid", bv_a, 1'b0);
    chk("reset_done", done_a, 1'b0);
    chk("reset_rd_en", rd_en_a, 1'b0);
    chk("reset_rd_addr", rd_addr_a, '0);
    chk("reset_buf_set", bs_a, '0);
    chk("reset_evict_buf", eb_a, '0);
    chk("reset_hit", hit_a, 1'b0);
    chk("reset_way", way_a, '0);
    chk("reset_state0", sb_a[0], '0);
    chk("reset_line15", lb_a[15], '0);

    // Directed set 0x3A with random content and a few lookups.
    rand_content(20);
    do_read_a("set3a", 8'h3A, 1'b0);
    for (int i = 0; i < 4; i++)
      check_lookup_a($sformatf("lk3a_%0d", i), c_tag[$urandom_range(W - 1)]);

    // Two matching ways: lowest index wins.
    rand_content(0);
    c_state[5] = VALID;
    c_tag[5] = 12'h1F2;
    c_state[9] = SHARED;
    c_tag[9] = 12'h1F2;
    do_read_a("hitset", set_t'($urandom), 1'b0);
    check_lookup_a("hit1f2", 12'h1F2);
    chk("hit1f2_const_hit", hit_a, 1'b1);
    chk("hit1f2_const_hw", hw_a, 4'd5);
    chk("hit1f2_const_way", way_a, 4'd5);

    rand_content(0);
    c_state[0] = VALID;
    c_state[1] = VALID;
    c_state[2] = VALID;
    c_state[3] = INVALID;
    do_read_a("emptyset", set_t'($urandom), 1'b0);
    check_lookup_a("empty", 12'hABC);
    chk("empty_const_ef", ef_a, 1'b1);
    chk("empty_const_ew", ew_a, 4'd3);
    chk("empty_const_way", way_a, 4'd3);

    rand_content(0);
    c_evict = 4'd7;
    do_read_a("evictset", set_t'($urandom), 1'b0);
    check_lookup_a("evict", 12'hABC);
    chk("evict_const_way", way_a, 4'd7);

    // buf_clear while idle drops valid and gates lookup, contents stay.
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    #1;
    chk("clear_buf_valid", bv_a, 1'b0);
    chk("clear_hit", hit_a, 1'b0);
    chk("clear_empty", ef_a, 1'b0);
    chk("clear_way", way_a, '0);
    chk("clear_line_kept", lb_a[0], c_line[0]);
    pv_valid = 1'b0;

    rand_content(30);
    do_read_a("clrcap", set_t'($urandom), 1'b1);

    for (int r = 0; r < 3; r++) begin
      rand_content(25);
      do_read_a($sformatf("rnd%0d", r), set_t'($urandom), 1'b0);
      for (int i = 0; i < 3; i++)
        check_lookup_a($sformatf("rnd%0d_lk%0d", r, i),
                       ($urandom_range(3) == 0) ? llc_tag_t'($urandom) : c_tag[$urandom_range(W - 1)]);
    end

    // Request held continuously: one accept every RAM_LATENCY+1 cycles.
    rand_content(20);
    cur_set = set_t'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_a.rd_set_valid = (i <= 6);
      if_a.rd_set = cur_set;
      #1;
      en_seen[i] = rd_en_a;
      done_seen[i] = done_a;
    end
    if_a.rd_set_valid = 1'b0;
    chk("b2b_rd_en", en_seen, 10'b0001001001);
    chk("b2b_done", done_seen, 10'b1001001000);
    check_bufs_a("b2b");

    // Reset in T+1 aborts the read.
    rand_content(20);
    s_tmp = set_t'($urandom);
    cur_set = s_tmp;
    @(negedge clk);
    if_a.rd_set_valid = 1'b1;
    if_a.rd_set = s_tmp;
    #1;
    chk("abort_T_rd_en", rd_en_a, 1'b1);
    @(negedge clk);
    if_a.rd_set_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", if_a.rd_set_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("abort_done_%0d", i), done_a, 1'b0);
      chk($sformatf("abort_buf_valid_%0d", i), bv_a, 1'b0);
      chk($sformatf("abort_buf_set_%0d", i), bs_a, '0);
      chk($sformatf("abort_rd_addr_%0d", i), rd_addr_a, '0);
      chk($sformatf("abort_way_%0d", i), way_a, '0);
      @(negedge clk);
    end
    for (int w = 0; w < W; w++)
      chk($sformatf("abort_buf_w%0d", w), {sb_a[w], tb_a[w], lb_a[w][15:0], db_a[w]}, '0);
    chk("abort_evict_buf", eb_a, '0);
    pv_valid = 1'b0;

    // Latency-1 instance: done two cycles after acceptance.
    rand_content(25);
    s_tmp = set_t'($urandom);
    cur_set = s_tmp;
    @(negedge clk);
    if_b.rd_set_valid = 1'b1;
    if_b.rd_set = s_tmp;
    #1;
    chk("l1_T_rd_en", rd_en_b, 1'b1);
    chk("l1_T_rd_addr", rd_addr_b, s_tmp);
    @(negedge clk);
    if_b.rd_set_valid = 1'b0;
    #1;
    chk("l1_T1_done", done_b, 1'b0);
    chk("l1_T1_ready", if_b.rd_set_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("l1_T2_done", done_b, 1'b1);
    chk("l1_T2_buf_valid", bv_b, 1'b1);
    chk("l1_T2_buf_set", bs_b, s_tmp);
    chk("l1_T2_ready", if_b.rd_set_ready, 1'b1);
    for (int w = 0; w < W; w++) begin
      chk($sformatf("l1_meta_w%0d", w), {sb_b[w], tb_b[w], hb_b[w], ob_b[w], shb_b[w], db_b[w]},
          {c_state[w], c_tag[w], c_hprot[w], c_owner[w], c_sharers[w], c_dirty[w]});
      chk($sformatf("l1_line_w%0d", w), lb_b[w], c_line[w]);
    end
    chk("l1_evict", eb_b, c_evict);
    @(negedge clk);
    lookup_tag = c_tag[$urandom_range(W - 1)];
    #1;
    chk("l1_T3_done", done_b, 1'b0);
    model_lookup(lookup_tag, e_hit, e_hw, e_ef, e_ew, e_way);
    chk("l1_hit", hit_b, e_hit);
    chk("l1_hit_way", hw_b, e_hw);
    chk("l1_empty_way", ew_b, e_ew);
    chk("l1_way", way_b, e_way);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
